// File: rtl/sobel_gcd_cmd_sched.sv
// -----------------------------------------------------------------------------
// sobel_gcd_cmd_sched
//
// Command scheduler between the SPI slave front-end and the two compute
// engines. It decodes 16-bit command words {addr[7:0], data[7:0]} and uses
// them to:
//   - assemble the GCD operands in shadow registers and launch a GCD run.
//     Each run is guarded by a cycle timeout.
//   - hand gray pixels to the Sobel path one at a time.
//   - select which word (status, GCD result or Sobel result) is returned on
//     the next SPI frame.
// The GCD and Sobel sequencers are independent and may be busy at once.
//
// Ports:
//   clk_i              system clock
//   nreset_i           asynchronous active-low reset
//   cmd_valid_i        one-cycle pulse, cmd_data_i holds a new command
//   cmd_data_i         command word {addr, data}
//   tx_data_o          registered readback word for the next SPI frame
//   operand_a_o/_b_o   GCD operands, frozen for the duration of a run
//   gcd_enable_o       high while a GCD run is active
//   gcd_result_i       GCD result
//   gcd_done_i         GCD completion, only looked at during a run
//   prep_allowed_o     Sobel path enable
//   px_gray_o          gray pixel to the Sobel path
//   px_valid_o         one-cycle strobe qualifying px_gray_o
//   px_sobel_i         Sobel output pixel
//   pixel_completed_i  Sobel output valid, only looked at while waiting
//   busy_o             GCD busy OR Sobel busy
//   err_o              OR of the sticky error bits
// -----------------------------------------------------------------------------
module sobel_gcd_cmd_sched #(
    parameter int DATA_WIDTH     = 16,
    parameter int PIXEL_WIDTH    = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk_i,
    input  logic                   nreset_i,
    input  logic                   cmd_valid_i,
    input  logic [15:0]            cmd_data_i,
    output logic [15:0]            tx_data_o,
    output logic [DATA_WIDTH-1:0]  operand_a_o,
    output logic [DATA_WIDTH-1:0]  operand_b_o,
    output logic                   gcd_enable_o,
    input  logic [DATA_WIDTH-1:0]  gcd_result_i,
    input  logic                   gcd_done_i,
    output logic                   prep_allowed_o,
    output logic [PIXEL_WIDTH-1:0] px_gray_o,
    output logic                   px_valid_o,
    input  logic [PIXEL_WIDTH-1:0] px_sobel_i,
    input  logic                   pixel_completed_i,
    output logic                   busy_o,
    output logic                   err_o
);

    // Command addresses
    localparam logic [7:0] ADDR_OPA_LO = 8'h20;
    localparam logic [7:0] ADDR_OPA_HI = 8'h21;
    localparam logic [7:0] ADDR_OPB_LO = 8'h22;
    localparam logic [7:0] ADDR_OPB_HI = 8'h23;
    localparam logic [7:0] ADDR_START  = 8'h24;
    localparam logic [7:0] ADDR_PX     = 8'h30;
    localparam logic [7:0] ADDR_PREP   = 8'h31;
    localparam logic [7:0] ADDR_RDSEL  = 8'h40;
    localparam logic [7:0] ADDR_ERRCLR = 8'h4F;

    // Sequencer states
    localparam logic G_IDLE = 1'b0;
    localparam logic G_RUN  = 1'b1;
    localparam logic S_IDLE = 1'b0;
    localparam logic S_WAIT = 1'b1;

    // Read selector values (3 also returns status)
    localparam logic [1:0] SEL_GCD   = 2'd1;
    localparam logic [1:0] SEL_SOBEL = 2'd2;

    localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // -------------------------------------------------------------------------
    // Command decode
    // -------------------------------------------------------------------------
    logic [7:0] cmd_addr;
    logic [7:0] cmd_byte;
    logic       wr_opa_lo, wr_opa_hi, wr_opb_lo, wr_opb_hi;
    logic       gcd_start, px_write, prep_write, sel_write, err_clear;

    assign cmd_addr   = cmd_data_i[15:8];
    assign cmd_byte   = cmd_data_i[7:0];
    assign wr_opa_lo  = cmd_valid_i && (cmd_addr == ADDR_OPA_LO);
    assign wr_opa_hi  = cmd_valid_i && (cmd_addr == ADDR_OPA_HI);
    assign wr_opb_lo  = cmd_valid_i && (cmd_addr == ADDR_OPB_LO);
    assign wr_opb_hi  = cmd_valid_i && (cmd_addr == ADDR_OPB_HI);
    assign gcd_start  = cmd_valid_i && (cmd_addr == ADDR_START) && cmd_byte[0];
    assign px_write   = cmd_valid_i && (cmd_addr == ADDR_PX);
    assign prep_write = cmd_valid_i && (cmd_addr == ADDR_PREP);
    assign sel_write  = cmd_valid_i && (cmd_addr == ADDR_RDSEL);
    assign err_clear  = cmd_valid_i && (cmd_addr == ADDR_ERRCLR) && cmd_byte[0];

    // -------------------------------------------------------------------------
    // Operand shadow registers; a running GCD keeps its own frozen copy.
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] shadow_a, shadow_b;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create order races.
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            shadow_a <= '0;
            shadow_b <= '0;
        end else begin
            if (wr_opa_lo) shadow_a[7:0] <= cmd_byte;
            // High byte keeps only the bits that fit above bit 7.
            if (wr_opa_hi) shadow_a[DATA_WIDTH-1:8] <= cmd_byte[DATA_WIDTH-9:0];
            if (wr_opb_lo) shadow_b[7:0] <= cmd_byte;
            if (wr_opb_hi) shadow_b[DATA_WIDTH-1:8] <= cmd_byte[DATA_WIDTH-9:0];
        end
    end

    // -------------------------------------------------------------------------
    // GCD sequencer with timeout
    // -------------------------------------------------------------------------
    logic                  gcd_state;
    logic [CNT_W-1:0]      run_cnt;
    logic                  gcd_done;
    logic [DATA_WIDTH-1:0] gcd_result_q;
    logic                  gcd_busy;
    logic                  ev_gcd_busy, ev_timeout;

    assign gcd_busy    = (gcd_state == G_RUN);
    assign ev_gcd_busy = gcd_start && gcd_busy;
    // Completion in the last allowed cycle takes priority over the timeout.
    assign ev_timeout  = gcd_busy && !gcd_done_i && (run_cnt == CNT_LAST);

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            gcd_state    <= G_IDLE;
            run_cnt      <= '0;
            gcd_done     <= 1'b0;
            gcd_result_q <= '0;
            operand_a_o  <= '0;
            operand_b_o  <= '0;
        end else begin
            case (gcd_state)
                G_IDLE: begin
                    if (gcd_start) begin
                        operand_a_o <= shadow_a;
                        operand_b_o <= shadow_b;
                        gcd_done    <= 1'b0;
                        run_cnt     <= '0;
                        gcd_state   <= G_RUN;
                    end
                end
                G_RUN: begin
                    if (gcd_done_i) begin
                        gcd_result_q <= gcd_result_i;
                        gcd_done     <= 1'b1;
                        gcd_state    <= G_IDLE;
                    end else if (run_cnt == CNT_LAST) begin
                        gcd_state <= G_IDLE;
                    end else begin
                        run_cnt <= run_cnt + CNT_W'(1);
                    end
                end
                default: gcd_state <= G_IDLE;
            endcase
        end
    end

    assign gcd_enable_o = gcd_busy;

    // -------------------------------------------------------------------------
    // Sobel pixel sequencer
    // -------------------------------------------------------------------------
    logic                   sobel_state;
    logic                   sobel_done;
    logic [PIXEL_WIDTH-1:0] sobel_result_q;
    logic                   sobel_busy;
    logic                   px_accept, ev_px;

    assign sobel_busy = (sobel_state == S_WAIT);
    assign px_accept  = px_write && !sobel_busy && prep_allowed_o;
    assign ev_px      = px_write && !px_accept;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            sobel_state    <= S_IDLE;
            sobel_done     <= 1'b0;
            sobel_result_q <= '0;
            prep_allowed_o <= 1'b0;
            px_gray_o      <= '0;
            px_valid_o     <= 1'b0;
        end else begin
            px_valid_o <= 1'b0;
            if (prep_write) prep_allowed_o <= cmd_byte[0];
            case (sobel_state)
                S_IDLE: begin
                    if (px_accept) begin
                        px_gray_o   <= cmd_byte[PIXEL_WIDTH-1:0];
                        px_valid_o  <= 1'b1;
                        sobel_done  <= 1'b0;
                        sobel_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Dropping prep_allowed_o here does not abandon the pixel.
                    if (pixel_completed_i) begin
                        sobel_result_q <= px_sobel_i;
                        sobel_done     <= 1'b1;
                        sobel_state    <= S_IDLE;
                    end
                end
                default: sobel_state <= S_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Sticky errors: a new error event outranks a clear in the same cycle.
    // -------------------------------------------------------------------------
    logic err_timeout, err_px, err_gcd_busy;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            err_timeout  <= 1'b0;
            err_px       <= 1'b0;
            err_gcd_busy <= 1'b0;
        end else begin
            err_timeout  <= (err_timeout  && !err_clear) || ev_timeout;
            err_px       <= (err_px       && !err_clear) || ev_px;
            err_gcd_busy <= (err_gcd_busy && !err_clear) || ev_gcd_busy;
        end
    end

    assign err_o  = err_timeout || err_px || err_gcd_busy;
    assign busy_o = gcd_busy || sobel_busy;

    // -------------------------------------------------------------------------
    // Readback selection, registered so the SPI frame sees a stable word.
    // -------------------------------------------------------------------------
    logic [1:0]  read_sel;
    logic [15:0] status_word, gcd_ext, sobel_ext, tx_next;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            read_sel <= 2'd0;
        end else if (sel_write) begin
            read_sel <= cmd_byte[1:0];
        end
    end

    // NOTE: every signal assigned in this block receives a default first,
    // so no path through the case leaves a value held (no inferred latch).
    always_comb begin
        status_word = {8'hA5, 1'b0, err_timeout, err_px, err_gcd_busy,
                       sobel_done, sobel_busy, gcd_done, gcd_busy};
        gcd_ext     = '0;
        gcd_ext[DATA_WIDTH-1:0] = gcd_result_q;
        sobel_ext   = '0;
        sobel_ext[PIXEL_WIDTH-1:0] = sobel_result_q;
        tx_next     = status_word;
        case (read_sel)
            SEL_GCD:   tx_next = gcd_ext;
            SEL_SOBEL: tx_next = sobel_ext;
            default:   tx_next = status_word;
        endcase
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            tx_data_o <= '0;
        end else begin
            tx_data_o <= tx_next;
        end
    end

endmodule

// File: tb/tb_sobel_gcd_cmd_sched.sv
// -----------------------------------------------------------------------------
// tb_sobel_gcd_cmd_sched
//
// Directed bench for sobel_gcd_cmd_sched. The driver issues commands and
// pushes the expected response into one of three queues; independent
// monitors pop and compare whenever the DUT presents the matching event:
//   px_q  : px_valid_o strobe          -> expected px_gray_o
//   gcd_q : end of a gcd_enable_o run  -> operands and run length
//   rd_q  : SPI frame sample (rd_req)  -> tx_data_o, err_o, busy_o
// Small behavioural models of the GCD and Sobel engines answer after a
// programmable number of cycles (0 = never answer).
// -----------------------------------------------------------------------------
module tb_sobel_gcd_cmd_sched;

    localparam int DW = 16;
    localparam int PW = 8;
    localparam int TO = 16;

    logic          clk_i;
    logic          nreset_i;
    logic          cmd_valid_i;
    logic [15:0]   cmd_data_i;
    logic [15:0]   tx_data_o;
    logic [DW-1:0] operand_a_o;
    logic [DW-1:0] operand_b_o;
    logic          gcd_enable_o;
    logic [DW-1:0] gcd_result_i;
    logic          gcd_done_i;
    logic          prep_allowed_o;
    logic [PW-1:0] px_gray_o;
    logic          px_valid_o;
    logic [PW-1:0] px_sobel_i;
    logic          pixel_completed_i;
    logic          busy_o;
    logic          err_o;

    sobel_gcd_cmd_sched #(
        .DATA_WIDTH    (DW),
        .PIXEL_WIDTH   (PW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i            (clk_i),
        .nreset_i         (nreset_i),
        .cmd_valid_i      (cmd_valid_i),
        .cmd_data_i       (cmd_data_i),
        .tx_data_o        (tx_data_o),
        .operand_a_o      (operand_a_o),
        .operand_b_o      (operand_b_o),
        .gcd_enable_o     (gcd_enable_o),
        .gcd_result_i     (gcd_result_i),
        .gcd_done_i       (gcd_done_i),
        .prep_allowed_o   (prep_allowed_o),
        .px_gray_o        (px_gray_o),
        .px_valid_o       (px_valid_o),
        .px_sobel_i       (px_sobel_i),
        .pixel_completed_i(pixel_completed_i),
        .busy_o           (busy_o),
        .err_o            (err_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] cycles;
    } gcd_exp_t;

    typedef struct packed {
        logic [15:0] tx;
        logic        err;
        logic        busy;
    } rd_exp_t;

    logic [PW-1:0] px_q[$];
    gcd_exp_t      gcd_q[$];
    rd_exp_t       rd_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Engine models
    // -------------------------------------------------------------------------
    int   gcd_lat = 0;
    int   sob_lat = 0;
    logic sob_model_done;
    logic force_pulse;

    assign pixel_completed_i = sob_model_done | force_pulse;

    // GCD model + monitor: counts enabled cycles, answers after gcd_lat,
    // and checks each completed run against the head of gcd_q.
    initial begin
        int            run_len;
        logic          active;
        logic          op_changed;
        logic [DW-1:0] first_a, first_b;
        gcd_exp_t      e;
        run_len    = 0;
        active     = 1'b0;
        op_changed = 1'b0;
        first_a    = '0;
        first_b    = '0;
        gcd_done_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!nreset_i) begin
                active     = 1'b0;
                run_len    = 0;
                gcd_done_i = 1'b0;
            end else if (gcd_enable_o) begin
                if (!active) begin
                    active     = 1'b1;
                    run_len    = 0;
                    op_changed = 1'b0;
                    first_a    = operand_a_o;
                    first_b    = operand_b_o;
                end
                run_len++;
                if (operand_a_o !== first_a || operand_b_o !== first_b) op_changed = 1'b1;
                gcd_done_i = (gcd_lat != 0) && (run_len == gcd_lat);
            end else begin
                gcd_done_i = 1'b0;
                if (active) begin
                    active = 1'b0;
                    if (gcd_q.size() == 0) begin
                        check("gcd_unexpected_run_len", 64'(run_len), 64'd0);
                    end else begin
                        e = gcd_q.pop_front();
                        check("gcd_operand_a", 64'(first_a), 64'(e.a));
                        check("gcd_operand_b", 64'(first_b), 64'(e.b));
                        check("gcd_enable_cycles", 64'(run_len), 64'(e.cycles));
                        check("gcd_operands_frozen", 64'(op_changed), 64'd0);
                    end
                end
            end
        end
    end

    // Sobel model: answers sob_lat cycles after each accepted pixel.
    initial begin
        int sob_cnt;
        sob_cnt        = 0;
        sob_model_done = 1'b0;
        forever begin
            @(negedge clk_i);
            sob_model_done = 1'b0;
            if (!nreset_i) begin
                sob_cnt = 0;
            end else if (px_valid_o && sob_lat != 0) begin
                sob_cnt = sob_lat;
            end else if (sob_cnt != 0) begin
                sob_cnt--;
                if (sob_cnt == 0) sob_model_done = 1'b1;
            end
        end
    end

    // Pixel strobe monitor
    initial begin
        logic [PW-1:0] e;
        forever begin
            @(negedge clk_i);
            if (nreset_i && px_valid_o) begin
                if (px_q.size() == 0) begin
                    check("px_valid_unexpected", 64'(px_valid_o), 64'd0);
                end else begin
                    e = px_q.pop_front();
                    check("px_gray", 64'(px_gray_o), 64'(e));
                end
            end
        end
    end

    // SPI frame monitor
    logic rd_req;

    initial begin
        rd_exp_t e;
        forever begin
            @(negedge clk_i);
            if (rd_req && rd_q.size() != 0) begin
                e = rd_q.pop_front();
                check("tx_data", 64'(tx_data_o), 64'(e.tx));
                check("err_o", 64'(err_o), 64'(e.err));
                check("busy_o", 64'(busy_o), 64'(e.busy));
            end
        end
    end

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    task automatic send_cmd(input logic [15:0] w);
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b1;
        cmd_data_i  = w;
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
        cmd_data_i  = '0;
    endtask

    task automatic expect_rd(input logic [15:0] tx, input logic err, input logic busy);
        rd_exp_t e;
        e.tx   = tx;
        e.err  = err;
        e.busy = busy;
        @(posedge clk_i); #1;
        rd_q.push_back(e);
        rd_req = 1'b1;
        @(posedge clk_i); #1;
        rd_req = 1'b0;
    endtask

    task automatic read_back(input logic [1:0] sel, input logic [15:0] tx,
                             input logic err, input logic busy);
        send_cmd({8'h40, 6'b0, sel});
        expect_rd(tx, err, busy);
    endtask

    task automatic start_gcd(input logic [15:0] a, input logic [15:0] b, input int lat,
                             input logic [15:0] res, input logic [15:0] cycles);
        gcd_exp_t e;
        e.a          = a;
        e.b          = b;
        e.cycles     = cycles;
        gcd_lat      = lat;
        gcd_result_i = res;
        gcd_q.push_back(e);
        send_cmd(16'h2401);
    endtask

    task automatic wait_gcd_idle(input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (!gcd_enable_o) begin
                ok = 1'b1;
                break;
            end
        end
        check("gcd_run_terminates", 64'(ok), 64'd1);
    endtask

    task automatic wait_all_idle(input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (!busy_o) begin
                ok = 1'b1;
                break;
            end
        end
        check("busy_clears", 64'(ok), 64'd1);
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({tx_data_o, operand_a_o, operand_b_o, gcd_enable_o, prep_allowed_o,
                    px_gray_o, px_valid_o, busy_o, err_o});
    endfunction

    // Hard stop in case something upstream never returns.
    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        nreset_i     = 1'b0;
        cmd_valid_i  = 1'b0;
        cmd_data_i   = '0;
        gcd_result_i = '0;
        px_sobel_i   = '0;
        force_pulse  = 1'b0;
        rd_req       = 1'b0;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_outputs", all_outputs(), 64'd0);
        nreset_i = 1'b1;
        expect_rd(16'hA500, 1'b0, 1'b0);

        // Basic GCD run: A=0x30, B=0x48, result 0x18 after 5 cycles
        send_cmd(16'h2030);
        send_cmd(16'h2100);
        send_cmd(16'h2248);
        send_cmd(16'h2300);
        start_gcd(16'h0030, 16'h0048, 5, 16'h0018, 16'd5);
        wait_gcd_idle(40);
        read_back(2'd1, 16'h0018, 1'b0, 1'b0);
        read_back(2'd0, 16'hA502, 1'b0, 1'b0);

        // START while running, shadow write during run must not leak
        start_gcd(16'h0030, 16'h0048, 12, 16'h0007, 16'd12);
        send_cmd(16'h2011);
        send_cmd(16'h2401);
        wait_gcd_idle(40);
        read_back(2'd0, 16'hA512, 1'b1, 1'b0);
        read_back(2'd1, 16'h0007, 1'b1, 1'b0);
        send_cmd(16'h4F01);
        read_back(2'd0, 16'hA502, 1'b0, 1'b0);

        // Timeout: engine never answers, result register untouched
        start_gcd(16'h0011, 16'h0048, 0, 16'hBEEF, 16'(TO));
        wait_gcd_idle(60);
        read_back(2'd0, 16'hA540, 1'b1, 1'b0);
        read_back(2'd1, 16'h0007, 1'b1, 1'b0);
        send_cmd(16'h4F01);
        read_back(2'd3, 16'hA500, 1'b0, 1'b0);

        // Completion in the final allowed cycle beats the timeout
        start_gcd(16'h0011, 16'h0048, TO, 16'h0055, 16'(TO));
        wait_gcd_idle(60);
        read_back(2'd0, 16'hA502, 1'b0, 1'b0);
        read_back(2'd1, 16'h0055, 1'b0, 1'b0);

        // Sobel path: accepted pixel, then a pixel dropped while waiting
        send_cmd(16'h3101);
        sob_lat    = 20;
        px_sobel_i = 8'h33;
        px_q.push_back(8'h7F);
        send_cmd(16'h307F);
        read_back(2'd0, 16'hA506, 1'b0, 1'b1);
        send_cmd(16'h3010);
        read_back(2'd0, 16'hA526, 1'b1, 1'b1);
        wait_all_idle(60);
        read_back(2'd2, 16'h0033, 1'b1, 1'b0);
        read_back(2'd0, 16'hA52A, 1'b1, 1'b0);

        // pixel_completed_i while idle is ignored
        @(posedge clk_i); #1;
        px_sobel_i  = 8'h99;
        force_pulse = 1'b1;
        @(posedge clk_i); #1;
        force_pulse = 1'b0;
        px_sobel_i  = 8'h33;
        read_back(2'd2, 16'h0033, 1'b1, 1'b0);

        // Pixel dropped because the Sobel path is disabled
        send_cmd(16'h4F01);
        read_back(2'd0, 16'hA50A, 1'b0, 1'b0);
        send_cmd(16'h3100);
        send_cmd(16'h3010);
        read_back(2'd0, 16'hA52A, 1'b1, 1'b0);

        // Asynchronous reset with both sequencers busy
        send_cmd(16'h4F01);
        send_cmd(16'h3101);
        sob_lat = 0;
        px_q.push_back(8'h44);
        send_cmd(16'h3044);
        read_back(2'd2, 16'h0033, 1'b0, 1'b1);
        gcd_lat = 0;
        send_cmd(16'h2401);
        @(posedge clk_i); #3;
        check("gcd_enable_before_reset", 64'(gcd_enable_o), 64'd1);
        #2;
        nreset_i = 1'b0;
        #1;
        check("async_reset_outputs", all_outputs(), 64'd0);
        repeat (3) @(posedge clk_i);
        #2;
        nreset_i = 1'b1;
        expect_rd(16'hA500, 1'b0, 1'b0);
        read_back(2'd1, 16'h0000, 1'b0, 1'b0);
        read_back(2'd2, 16'h0000, 1'b0, 1'b0);

        // Every pushed expectation must have been consumed
        repeat (4) @(posedge clk_i);
        check("px_queue_drained", 64'(px_q.size()), 64'd0);
        check("gcd_queue_drained", 64'(gcd_q.size()), 64'd0);
        check("rd_queue_drained", 64'(rd_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sobel_gcd_cmd_sched.md
Name: sobel_gcd_cmd_sched

Overview:
Command scheduler between the SPI slave front-end and the two compute engines (GCD and Sobel pixel path). It decodes 16-bit command words (address byte [15:8], data byte [7:0]), assembles GCD operands, and sequences each GCD run with a timeout. It feeds gray pixels into the Sobel path one at a time and arbitrates the single SPI readback word between status, the GCD result and the Sobel result.

Parameters:
DATA_WIDTH, 16, GCD operand/result width; legal range 9..16.
PIXEL_WIDTH, 8, Sobel pixel width; legal range 1..8.
TIMEOUT_CYCLES, 1024, maximum clk_i cycles a GCD run may last before it is aborted; must be at least 2.

Ports:
clk_i  in  1  system clock
nreset_i  in  1  asynchronous active-low reset
cmd_valid_i  in  1  one-cycle pulse: cmd_data_i holds a new command word
cmd_data_i  in  16  command word {addr[7:0], data[7:0]}
tx_data_o  out  16  readback word for the next SPI frame
operand_a_o  out  DATA_WIDTH  GCD operand A, frozen during a run
operand_b_o  out  DATA_WIDTH  GCD operand B, frozen during a run
gcd_enable_o  out  1  high while a GCD run is active
gcd_result_i  in  DATA_WIDTH  GCD result
gcd_done_i  in  1  GCD completion, sampled only while a run is active
prep_allowed_o  out  1  Sobel path enable
px_gray_o  out  PIXEL_WIDTH  gray pixel to the Sobel path
px_valid_o  out  1  one-cycle strobe: px_gray_o is valid
px_sobel_i  in  PIXEL_WIDTH  Sobel output pixel
pixel_completed_i  in  1  Sobel output valid
busy_o  out  1  GCD busy OR Sobel busy
err_o  out  1  OR of the sticky error bits

Behaviour:
- Reset: every output is 0, all shadow registers and flags are 0, both FSMs are IDLE, and the read selector is STATUS. A reset mid-operation aborts the run immediately; no result is latched.
- A command is acted on only in a cycle where cmd_valid_i=1. Unlisted addresses are ignored with no error.
- 0x20/0x21 write the OPA shadow low/high byte. 0x22/0x23 write the OPB shadow low/high byte. High-byte bits above DATA_WIDTH-8 are dropped. Shadow writes are allowed during a run and do not change operand_*_o.
- 0x24 with data[0]=1 is GCD START.
  - GCD FSM in G_IDLE: copy the shadows into operand_a_o/operand_b_o, clear gcd_done, go to G_RUN. gcd_enable_o=1 from the next cycle.
  - GCD FSM in G_RUN: set sticky err_gcd_busy; the run continues unaffected.
- G_RUN, on gcd_done_i=1: latch gcd_result_i into the result register, set gcd_done, gcd_enable_o=0 in the next cycle, return to G_IDLE.
- Timeout: a cycle counter is cleared on entry to G_RUN. At count TIMEOUT_CYCLES-1 without gcd_done_i, abort to G_IDLE and set sticky err_timeout; gcd_done stays 0 and the result is unchanged. If gcd_done_i arrives in the timeout cycle, done wins.
- 0x31 writes prep_allowed_o <= data[0]. Clearing it while in S_WAIT does not abort the wait.
- 0x30 is PX_WRITE with data[PIXEL_WIDTH-1:0] as the pixel.
  - Sobel FSM in S_IDLE with prep_allowed_o=1: drive px_gray_o, pulse px_valid_o for the next cycle, clear sobel_done, go to S_WAIT.
  - prep_allowed_o=0, or FSM already in S_WAIT: drop the pixel (no strobe) and set sticky err_px.
- S_WAIT, on pixel_completed_i=1: latch px_sobel_i, set sobel_done, return to S_IDLE. pixel_completed_i is ignored in S_IDLE.
- 0x40 sets the read selector from data[1:0]: 0 = STATUS, 1 = GCD result (zero-extended to 16), 2 = Sobel result (zero-extended), 3 = STATUS.
- 0x4F with data[0]=1 clears all sticky errors. An error event in the same cycle wins (bit stays set).
- STATUS word: [15:8]=0xA5, [7]=0, [6]=err_timeout, [5]=err_px, [4]=err_gcd_busy, [3]=sobel_done, [2]=sobel_busy, [1]=gcd_done, [0]=gcd_busy.
- tx_data_o is registered: it reflects the selector and state of the previous cycle, so latency is 1 cycle from any update.
- GCD and Sobel FSMs are independent and may run concurrently; a single command touches only one of them.

Test Plan:
- Write 0x2030, 0x2100, 0x2248, 0x2300, 0x2401. Model gcd_done_i 5 cycles later with result 0x0018 -> operand_a_o=0x0030 and operand_b_o=0x0048 during the run; gcd_enable_o high 5 cycles; after 0x4001, tx_data_o=0x0018; status bit1=1.
- Issue 0x2401 while in G_RUN -> status bit4=1 and err_o=1; the run completes normally. Then 0x4F01 -> err_o=0.
- Start GCD with gcd_done_i never asserted, TIMEOUT_CYCLES=16 -> gcd_enable_o drops after 16 cycles; status=0xA540; result register unchanged.
- Write 0x3101 then 0x307F -> px_valid_o one cycle with px_gray_o=0x7F. pixel_completed_i with px_sobel_i=0x33 -> after 0x4002, tx_data_o=0x0033.
- Issue 0x3010 while in S_WAIT, and 0x3010 with prep_allowed_o=0 -> no px_valid_o in either case; err_px set.
- Assert nreset_i low during G_RUN and S_WAIT -> all outputs 0 asynchronously; after release, status readback is 0xA500.
